// File: rtl/scratch_pkg.sv
// Shared scratch-RAM definitions: word/address widths and block-mover enums.
package scratch_pkg;

  localparam int unsigned SCR_DATA_W = 10;
  localparam int unsigned SCR_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } mover_state_e;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } mover_mode_e;

endpackage

// File: rtl/scratch_block_mover.sv
// Scratch RAM block mover: copies a word block between scratch locations or
// fills it with a constant, one word per WR cycle, ascending with wrap.
module scratch_block_mover
  import scratch_pkg::*;
#(
  parameter int unsigned DATA_W = SCR_DATA_W,
  parameter int unsigned ADDR_W = SCR_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   src_i,
  input  logic [ADDR_W-1:0]   dst_i,
  input  logic [ADDR_W:0]     len_i,
  input  logic [DATA_W-1:0]   fill_val_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_din_o,
  input  logic [DATA_W-1:0]   ram_dout_i
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  mover_state_e        state_q, state_d;
  mover_mode_e         mode_q,  mode_d;
  logic [DATA_W-1:0]   fill_q,  fill_d;
  logic [DATA_W-1:0]   hold_q,  hold_d;
  logic [ADDR_W-1:0]   src_q,   src_d;
  logic [ADDR_W-1:0]   dst_q,   dst_d;
  logic [CNT_W-1:0]    rem_q,   rem_d;

  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   din_q,   din_d;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_d = FIN;
          end else begin
            mode_d  = mover_mode_e'(mode_i);
            fill_d  = fill_val_i;
            src_d   = src_i;
            dst_d   = dst_i;
            rem_d   = len_i;
            state_d = (mover_mode_e'(mode_i) == FILL) ? WR : RD;
          end
        end
      end
      RD: begin
        hold_d  = ram_dout_i;
        src_d   = src_q + ADDR_W'(1);
        state_d = WR;
      end
      WR: begin
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = FIN;
        end else if (mode_q == COPY) begin
          state_d = RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next register values so they come straight off flops
    busy_d = (state_d == RD) || (state_d == WR);
    done_d = (state_d == FIN);
    we_d   = (state_d == WR);
    addr_d = '0;
    din_d  = '0;
    case (state_d)
      RD: begin
        addr_d = src_d;
      end
      WR: begin
        addr_d = dst_d;
        din_d  = (mode_d == FILL) ? fill_d : hold_d;
      end
      default: begin
        addr_d = '0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= COPY;
      fill_q  <= '0;
      hold_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;

endmodule

// File: tb/tb_scratch_block_mover.sv
// Scoreboard bench for scratch_block_mover: a sequential block-transfer model
// predicts every RAM write, DONE timing and final RAM contents.
module tb_scratch_block_mover;

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          mode_i;
  logic [AW-1:0] src_i;
  logic [AW-1:0] dst_i;
  logic [AW:0]   len_i;
  logic [DW-1:0] fill_val_i;
  logic          busy_o;
  logic          done_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_din_o;
  logic [DW-1:0] ram_dout_i;

  scratch_block_mover #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .src_i      (src_i),
    .dst_i      (dst_i),
    .len_i      (len_i),
    .fill_val_i (fill_val_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_din_o  (ram_din_o),
    .ram_dout_i (ram_dout_i)
  );

  always #5 clk = ~clk;

  // Scratch RAM model: combinational read, write on rising edge
  logic [DW-1:0] mem [256];
  assign ram_dout_i = mem[ram_addr_o];
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  typedef struct {
    int at;
    int busy;
  } done_t;

  wr_t           wq[$];
  done_t         dq[$];
  logic [DW-1:0] ref_mem [256];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            busy_run = 0;
  bit            chk_en = 1'b1;

  // Monitor: checks each presented write and each DONE against the scoreboard
  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy_o) busy_run++;
      if (ram_we_o && chk_en) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", ram_addr_o, ram_din_o, cyc);
        end else begin
          e = wq.pop_front();
          if (ram_addr_o !== e.a || ram_din_o !== e.d) begin
            n_fail++;
            $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", ram_addr_o, ram_din_o, e.a, e.d);
          end
        end
      end
      if (done_o) begin
        n_tests++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          d = dq.pop_front();
          if (cyc != d.at || busy_run != d.busy || wq.size() != 0) begin
            n_fail++;
            $display("FAIL done got cyc=%0d busy=%0d pend=%0d exp cyc=%0d busy=%0d pend=0",
                     cyc, busy_run, wq.size(), d.at, d.busy);
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic check_idle(input string name);
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || ram_we_o !== 1'b0 ||
        ram_addr_o !== '0 || ram_din_o !== '0) begin
      n_fail++;
      $display("FAIL %s got busy=%b done=%b we=%b addr=%h din=%h exp all zero",
               name, busy_o, done_o, ram_we_o, ram_addr_o, ram_din_o);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s got %0d differing words (first at %0d: %h) exp 0 (ref %h)",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Reference transfer: words handled in ascending order, each read after all earlier writes
  task automatic model_op(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int len, input logic [DW-1:0] fill, input int keep, input bit push);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      a = dst + AW'(i);
      d = mode ? fill : ref_mem[src + AW'(i)];
      if (i < keep) ref_mem[a] = d;
      if (push) wq.push_back('{a: a, d: d});
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the DUT idle
  task automatic run_op(input string name, input bit mode, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input int len, input logic [DW-1:0] fill,
                        input bit noise);
    bit got = 1'b0;
    int k = mode ? len : 2 * len;
    model_op(mode, src, dst, len, fill, len, 1'b1);
    dq.push_back('{at: cyc + 1 + k, busy: k});
    start_i = 1'b1; mode_i = mode; src_i = src; dst_i = dst;
    len_i = (AW+1)'(len); fill_val_i = fill;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 0; n < 700 && !got; n++) begin
      if (done_o) begin
        got = 1'b1;
      end else begin
        start_i = noise && busy_o;
        if (noise) begin
          mode_i = 1'($urandom_range(0, 1)); src_i = AW'($urandom);
          dst_i = AW'($urandom); len_i = (AW+1)'($urandom_range(0, 256));
          fill_val_i = DW'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout got no done exp done within budget", name);
      wq.delete(); dq.delete();
    end
    start_i = noise;
    if (noise) begin
      mode_i = 1'b1; dst_i = AW'($urandom); len_i = (AW+1)'(5); fill_val_i = DW'($urandom);
    end
    @(negedge clk);
    start_i = 1'b0;
    check_idle({name, "_idle"});
    check_mem({name, "_mem"});
  endtask

  initial begin
    int we_n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; src_i = '0; dst_i = '0;
    len_i = '0; fill_val_i = '0;
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("fill_basic", 1'b1, 8'h10, 8'h10, 4, 10'h2AA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem[i] = DW'(i + 1);
      ref_mem[i] = DW'(i + 1);
    end
    run_op("copy_basic", 1'b0, 8'h00, 8'h40, 3, 10'h000, 1'b0);
    run_op("fill_wrap", 1'b1, 8'h00, 8'hFE, 3, 10'h007, 1'b0);
    run_op("fill_256", 1'b1, 8'h00, 8'h37, 256, 10'h155, 1'b0);
    run_op("len_zero", 1'b0, 8'h05, 8'h06, 0, 10'h3FF, 1'b1);
    run_op("copy_noise", 1'b0, 8'h80, 8'h20, 7, 10'h000, 1'b1);
    mem[0] = 10'h0AA; mem[1] = 10'h0BB; mem[2] = 10'h0CC;
    ref_mem[0] = 10'h0AA; ref_mem[1] = 10'h0BB; ref_mem[2] = 10'h0CC;
    run_op("copy_overlap", 1'b0, 8'h00, 8'h01, 3, 10'h000, 1'b0);
    n_tests++;
    if (mem[0] !== 10'h0AA || mem[1] !== 10'h0AA || mem[2] !== 10'h0AA || mem[3] !== 10'h0AA) begin
      n_fail++;
      $display("FAIL overlap_words got %h %h %h %h exp 0aa x4", mem[0], mem[1], mem[2], mem[3]);
    end
    run_op("copy_256", 1'b0, 8'hC3, 8'h11, 256, 10'h000, 1'b0);

    // Reset mid-copy while the third write is being presented
    chk_en = 1'b0;
    model_op(1'b0, 8'h50, 8'hA0, 10, 10'h000, 2, 1'b0);
    start_i = 1'b1; mode_i = 1'b0; src_i = 8'h50; dst_i = 8'hA0; len_i = 9'd10;
    @(negedge clk);
    start_i = 1'b0;
    we_n = 0;
    for (int n = 0; n < 40 && we_n < 3; n++) begin
      if (ram_we_o) we_n++;
      if (we_n < 3) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_op("after_reset", 1'b1, 8'h00, 8'hD0, 2, 10'h123, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int ln = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 20));
      run_op("random", 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), ln,
             DW'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (wq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got writes=%0d dones=%0d pending exp 0", wq.size(), dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
